// File: rtl/nand_id_fetcher.sv
// Start-triggered READ ID sequencer in front of nand_master: chip enable, READ ID, then ID_BYTES byte fetches.
// Optional second READ ID (address 20h) with on-the-fly ONFI signature compare under NAND_ID_ONFI_CHECK_EN.
`timescale 1ns/1ps
`ifndef MI_CHIP_ENABLE
`define MI_CHIP_ENABLE 8'h09
`endif
`ifndef M_NAND_READ_ID
`define M_NAND_READ_ID 8'h03
`endif
`ifndef MI_GET_ID_BYTE
`define MI_GET_ID_BYTE 8'h0E
`endif

module nand_id_fetcher #(
  parameter int         ID_BYTES        = 5,
  parameter int         TIMEOUT_CYCLES  = 4096,
  parameter logic [7:0] CMD_CHIP_ENABLE = `MI_CHIP_ENABLE,
  parameter logic [7:0] CMD_READ_ID     = `M_NAND_READ_ID,
  parameter logic [7:0] CMD_GET_ID_BYTE = `MI_GET_ID_BYTE
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  nm_busy,
  input  logic [7:0]            nm_data_out,
  output logic [7:0]            nm_cmd_in,
  output logic [7:0]            nm_data_in,
  output logic                  nm_activate,
  output logic [8*ID_BYTES-1:0] id_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  onfi
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(ID_BYTES - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CE_ISSUE  = 4'd1;
  localparam logic [3:0] S_CE_WAIT   = 4'd2;
  localparam logic [3:0] S_RID_ISSUE = 4'd3;
  localparam logic [3:0] S_RID_WAIT  = 4'd4;
  localparam logic [3:0] S_GB_ISSUE  = 4'd5;
  localparam logic [3:0] S_GB_WAIT   = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ERROR     = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    guard_q, guard_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    cmd_q, cmd_d, din_q, din_d;
  logic          act_q, act_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic          cap_en, is_issue, is_wait, tmo_hit, wait_ready;
  logic [7:0]    id_q [ID_BYTES];
`ifdef NAND_ID_ONFI_CHECK_EN
  logic          phase_q, phase_d, ok_q, ok_d, onfi_q, onfi_d;

  function automatic logic [7:0] onfi_char(input logic [1:0] i);
    case (i)
      2'd0:    onfi_char = 8'h4F;
      2'd1:    onfi_char = 8'h4E;
      2'd2:    onfi_char = 8'h46;
      default: onfi_char = 8'h49;
    endcase
  endfunction
`endif

  assign is_issue   = (state_q == S_CE_ISSUE) || (state_q == S_RID_ISSUE) || (state_q == S_GB_ISSUE);
  assign is_wait    = (state_q == S_CE_WAIT) || (state_q == S_RID_WAIT) || (state_q == S_GB_WAIT);
  assign tmo_hit    = (tmo_q == TMO_LAST);
  // The first two WAIT cycles cover nand_master's busy rise latency after activate.
  assign wait_ready = is_wait && (guard_q == 2'd2) && !nm_busy;

  always_comb begin
    state_d = state_q; tmo_d = tmo_q; guard_d = guard_q; idx_d = idx_q;
    cmd_d = cmd_q; din_d = din_q; act_d = 1'b0; cap_en = 1'b0;
    busy_d = busy_q; done_d = done_q; timeout_d = timeout_q;
`ifdef NAND_ID_ONFI_CHECK_EN
    phase_d = phase_q; ok_d = ok_q; onfi_d = onfi_q;
`endif
    if (is_issue || is_wait) tmo_d = tmo_q + 1'b1;
    if (is_wait && guard_q != 2'd2) guard_d = guard_q + 2'd1;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) begin
        done_d = 1'b0; timeout_d = 1'b0; idx_d = '0; tmo_d = '0;
        busy_d = 1'b1; state_d = S_CE_ISSUE;
`ifdef NAND_ID_ONFI_CHECK_EN
        onfi_d = 1'b0; phase_d = 1'b0; ok_d = 1'b1;
`endif
      end
      S_CE_ISSUE, S_RID_ISSUE, S_GB_ISSUE: if (!nm_busy) begin
        act_d   = 1'b1;
        guard_d = 2'd0;
        din_d   = 8'h00;
        state_d = state_q + 4'd1;
        cmd_d   = (state_q == S_CE_ISSUE)  ? CMD_CHIP_ENABLE :
                  (state_q == S_RID_ISSUE) ? CMD_READ_ID : CMD_GET_ID_BYTE;
`ifdef NAND_ID_ONFI_CHECK_EN
        if (state_q == S_RID_ISSUE && phase_q) din_d = 8'h20;
`endif
      end
      S_CE_WAIT:  if (wait_ready) begin state_d = S_RID_ISSUE; tmo_d = '0; end
      S_RID_WAIT: if (wait_ready) begin state_d = S_GB_ISSUE;  tmo_d = '0; end
      S_GB_WAIT: if (wait_ready) begin
        tmo_d   = '0;
        idx_d   = idx_q + 4'd1;
        state_d = S_GB_ISSUE;
`ifdef NAND_ID_ONFI_CHECK_EN
        if (phase_q) begin
          ok_d = ok_q && (nm_data_out == onfi_char(idx_q[1:0]));
          if (idx_q == 4'd3) begin
            state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0; onfi_d = ok_d;
          end
        end else begin
          cap_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0; phase_d = 1'b1; state_d = S_RID_ISSUE;
          end
        end
`else
        cap_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Timeout wins over a same-cycle issue or capture so no activate follows an abort.
    if ((is_issue || is_wait) && tmo_hit) begin
      state_d = S_ERROR; timeout_d = 1'b1; busy_d = 1'b0; act_d = 1'b0; cap_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE; tmo_q <= '0; guard_q <= '0; idx_q <= '0;
      cmd_q <= 8'h00; din_q <= 8'h00; act_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; timeout_q <= 1'b0;
    end else begin
      state_q <= state_d; tmo_q <= tmo_d; guard_q <= guard_d; idx_q <= idx_d;
      cmd_q <= cmd_d; din_q <= din_d; act_q <= act_d;
      busy_q <= busy_d; done_q <= done_d; timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < ID_BYTES; i++) id_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < ID_BYTES; i++)
        if (cap_en && idx_q == 4'(i)) id_q[i] <= nm_data_out;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ID_BYTES; gi++) begin : g_id
      assign id_bytes[8*gi +: 8] = id_q[gi];
    end
  endgenerate

`ifdef NAND_ID_ONFI_CHECK_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase_q <= 1'b0; ok_q <= 1'b0; onfi_q <= 1'b0;
    end else begin
      phase_q <= phase_d; ok_q <= ok_d; onfi_q <= onfi_d;
    end
  end
  assign onfi = onfi_q;
`else
  assign onfi = 1'b0;
`endif

  assign nm_cmd_in   = cmd_q;
  assign nm_data_in  = din_q;
  assign nm_activate = act_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule
